// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: sequences one parallel word at a time into a PISO shift
// register: accept, load strobe, WIDTH data-bit cycles, optional parity
// cycle, then GAP idle cycles before the next word is accepted.
// Build option: define PISO_TX_PARITY_EN to append one even-parity cycle
// after the data bits of every frame.
//
// state     | meaning
// ST_IDLE   | waiting for a word, in_ready high
// ST_LOAD   | one-cycle load strobe, pin carries the captured word
// ST_SHIFT  | WIDTH data-bit cycles, frame high
// ST_PARITY | parity-bit cycle (parity builds only)
// ST_GAP    | GAP quiet cycles before returning to ST_IDLE
module piso_tx_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             load,
  output logic [WIDTH-1:0] pin,
  output logic             frame,
  output logic             last,
  output logic             par_valid,
  output logic             par_bit,
  output logic             done,
  output logic [7:0]       frame_cnt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = 4;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
`ifdef PISO_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_GAP
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic            capture;
  logic            load_nxt;
  logic            frame_nxt;
  logic            last_nxt;
  logic            done_nxt;
  logic            par_nxt;

  // Next-state logic plus the D-side of every registered output.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    capture     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt = ST_LOAD;
          capture   = 1'b1;
        end
      end
      ST_LOAD: begin
        state_nxt   = ST_SHIFT;
        bit_cnt_nxt = '0;
      end
      ST_SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
`ifdef PISO_TX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          if (GAP > 0) begin
            state_nxt   = ST_GAP;
            gap_cnt_nxt = GAP_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
`endif
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        if (GAP > 0) begin
          state_nxt   = ST_GAP;
          gap_cnt_nxt = GAP_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so that, once registered,
    // they line up with the state they describe.
    load_nxt  = (state_nxt == ST_LOAD);
    frame_nxt = (state_nxt == ST_SHIFT);
    last_nxt  = frame_nxt && (bit_cnt_nxt == BIT_LAST);
`ifdef PISO_TX_PARITY_EN
    par_nxt   = (state_nxt == ST_PARITY);
    done_nxt  = par_nxt;
`else
    par_nxt   = 1'b0;
    done_nxt  = last_nxt;
`endif
  end

  // State, counters, captured word and all registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      in_ready  <= 1'b1;
      load      <= 1'b0;
      pin       <= '0;
      frame     <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      load      <= load_nxt;
      frame     <= frame_nxt;
      last      <= last_nxt;
      done      <= done_nxt;
      if (capture) begin
        pin <= in_data;
      end
      if (done_nxt) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

`ifdef PISO_TX_PARITY_EN
  // Parity marker and even-parity bit of the word held on pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_valid <= 1'b0;
      par_bit   <= 1'b0;
    end else begin
      par_valid <= par_nxt;
      par_bit   <= par_nxt & (^pin);
    end
  end
`else
  assign par_valid = 1'b0;
  assign par_bit   = 1'b0;
`endif

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl: scoreboard bench for piso_tx_ctrl. A transaction model
// predicts when each word is accepted and pushes it to a queue; the checker
// pops an entry when the load for it is due and derives every output of the
// following cycles from the frame timing rules.
module tb_piso_tx_ctrl;

  localparam int W = 4;
  localparam int G = 1;
`ifdef PISO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int SPAN = W + P + G + 2;   // handshake-to-handshake minimum

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          load;
  logic [W-1:0]  pin;
  logic          frame;
  logic          last;
  logic          par_valid;
  logic          par_bit;
  logic          done;
  logic [7:0]    frame_cnt;
  logic          stim_done;

  piso_tx_ctrl #(.WIDTH(W), .GAP(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .load      (load),
    .pin       (pin),
    .frame     (frame),
    .last      (last),
    .par_valid (par_valid),
    .par_bit   (par_bit),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [W-1:0] data;
    int           hs_edge;
  } tx_t;

  tx_t          q[$];
  tx_t          cur;
  logic         cur_valid;
  logic [W-1:0] exp_pin;
  logic [7:0]   completed;
  int           cyc;
  int           accept_edge;
  int           rst_count;
  int           seen_rst;
  int           vectors;
  int           errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model at the rising edge, checker at the falling edge.
  initial begin
    int   k;
    logic e_load, e_frame, e_last, e_pv, e_pb, e_done, e_rdy;
    cyc = 0; accept_edge = 0; rst_count = 0; seen_rst = 0;
    vectors = 0; errors = 0; cur_valid = 1'b0; exp_pin = '0; completed = 8'd0;
    cur.data = '0; cur.hs_edge = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        rst_count   = rst_count + 1;
        accept_edge = cyc + 1;
      end else if (in_valid && cyc >= accept_edge) begin
        q.push_back('{data: in_data, hs_edge: cyc});
        accept_edge = cyc + SPAN;
      end

      @(negedge clk);
      if (rst_count != seen_rst) begin
        seen_rst  = rst_count;
        cur_valid = 1'b0;
        exp_pin   = '0;
        completed = 8'd0;
      end
      if (seen_rst != 0) begin
        e_load = 1'b0;
        if (q.size() != 0) begin
          if (q[0].hs_edge == cyc) begin
            cur       = q.pop_front();
            cur_valid = 1'b1;
            exp_pin   = cur.data;
            e_load    = 1'b1;
          end
        end
        k       = cyc - cur.hs_edge;
        e_frame = cur_valid && k >= 1 && k <= W;
        e_last  = cur_valid && k == W;
        e_pv    = cur_valid && P == 1 && k == W + 1;
        e_pb    = e_pv && (^cur.data);
        e_done  = cur_valid && k == W + P;
        e_rdy   = !cur_valid || k > W + P + G;
        chk("in_ready",  32'(in_ready),  32'(e_rdy));
        chk("load",      32'(load),      32'(e_load));
        chk("frame",     32'(frame),     32'(e_frame));
        chk("last",      32'(last),      32'(e_last));
        chk("par_valid", 32'(par_valid), 32'(e_pv));
        chk("par_bit",   32'(par_bit),   32'(e_pb));
        chk("done",      32'(done),      32'(e_done));
        chk("pin",       32'(pin),       32'(exp_pin));
        if (!e_done) begin
          chk("frame_cnt", 32'(frame_cnt), 32'(completed));
        end else begin
          completed = completed + 8'd1;
        end
      end
      if (stim_done) begin
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
      end
    end
  end

  // Values set here are sampled by the DUT at the next rising edge.
  task automatic drive(input logic r, input logic v, input logic [W-1:0] d);
    @(posedge clk);
    #2;
    rst      = r;
    in_valid = v;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; stim_done = 1'b0;
    drive(1'b1, 1'b0, '0);

    // Single word 1011; in_data flips to 0000 while the frame shifts.
    drive(1'b0, 1'b1, 4'b1011);
    repeat (3) drive(1'b0, 1'b1, 4'b0000);
    repeat (12) drive(1'b0, 1'b0, '0);

    // Reset during the second data-bit cycle aborts the frame.
    drive(1'b0, 1'b1, 4'b1011);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    repeat (10) drive(1'b0, 1'b0, '0);

    // Two words with in_valid held: 0101 then 1100.
    drive(1'b0, 1'b1, 4'b0101);
    repeat (SPAN) drive(1'b0, 1'b1, 4'b1100);
    repeat (12) drive(1'b0, 1'b0, '0);

    // Back-to-back frames from a fresh reset, enough to wrap frame_cnt.
    drive(1'b1, 1'b0, '0);
    repeat (256 * SPAN + 8) drive(1'b0, 1'b1, W'($urandom_range(0, 15)));
    repeat (12) drive(1'b0, 1'b0, '0);

    // Random traffic with occasional resets.
    repeat (1500) drive(1'b0 | ($urandom_range(0, 99) == 0),
                        1'b0 | ($urandom_range(0, 1) == 1),
                        W'($urandom_range(0, 15)));
    repeat (15) drive(1'b0, 1'b0, '0);

    @(posedge clk);
    #2;
    stim_done = 1'b1;
  end

endmodule

// File: doc/piso_tx_ctrl.md
PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: word width of the PISO register being sequenced; legal range 2..16.
REQ-002 Parameter GAP, default 1: idle cycles inserted after each frame before the next word is accepted; legal range 0..15.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  requester has a word on in_data.
REQ-006 in_data  input  WIDTH  parallel word to transmit.
REQ-007 in_ready  output  1  controller accepts a word this cycle.
REQ-008 load  output  1  load strobe to the PISO register.
REQ-009 pin  output  WIDTH  parallel word driven to the PISO register.
REQ-010 frame  output  1  high while the PISO sout carries a data bit.
REQ-011 last  output  1  high on the final data-bit cycle of a frame.
REQ-012 par_valid  output  1  parity cycle marker; tied 0 when parity is compiled out.
REQ-013 par_bit  output  1  parity bit; tied 0 when parity is compiled out.
REQ-014 done  output  1  one-cycle pulse at the end of each frame.
REQ-015 frame_cnt  output  8  count of completed frames.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, SHIFT, PARITY and GAP, and all outputs SHALL be registered.
REQ-017 in_ready SHALL be 1 only in IDLE; a handshake is in_valid & in_ready sampled at a rising edge.
REQ-018 On a handshake the controller SHALL capture in_data into an internal word register and move IDLE->LOAD.
REQ-019 LOAD SHALL last exactly 1 cycle with load=1 and pin=captured word, then move to SHIFT with the bit counter cleared.
REQ-020 pin SHALL hold the captured word from LOAD until the next handshake; load SHALL be 0 outside LOAD.
REQ-021 SHIFT SHALL last exactly WIDTH cycles with frame=1; last SHALL be 1 only when bit counter = WIDTH-1.
REQ-022 Latency: for a handshake at edge N, load is high in cycle N+1 and frame is high in cycles N+2..N+1+WIDTH.
REQ-023 After SHIFT the FSM SHALL go to PARITY if compiled in; otherwise to GAP if GAP>0; otherwise to IDLE.
REQ-024 GAP SHALL last exactly GAP cycles with all strobes at 0, then move to IDLE.
REQ-025 done SHALL pulse for 1 cycle on the final cycle of the frame: the PARITY cycle if parity is compiled in, otherwise the last=1 cycle.
REQ-026 frame_cnt SHALL increment on each done pulse and wrap from 255 to 0.
REQ-027 in_valid and in_data changes outside IDLE SHALL be ignored; a word is never dropped or duplicated.
REQ-028 With GAP=0 and in_valid held high, consecutive frames SHALL be separated by exactly 1 IDLE cycle.

Reset
REQ-029 While rst=1 at an edge: the FSM SHALL be in IDLE and in_ready=1 on the following cycle, with load, frame, last, par_valid, par_bit, done=0, pin=0 and frame_cnt=0.
REQ-030 A reset asserted mid-frame SHALL abort the frame without pulsing done or incrementing frame_cnt.

Configuration
REQ-031 Macro PISO_TX_PARITY_EN defined: one PARITY cycle follows SHIFT with par_valid=1 and par_bit = XOR of all bits of the captured word (even parity).
REQ-032 Macro PISO_TX_PARITY_EN undefined: no PARITY state exists, par_valid and par_bit are constant 0, and the frame is WIDTH cycles.

Verification
REQ-033 Reset, then in_valid=1, in_data=4'b1011 (defaults) -> load=1 one cycle with pin=1011, frame high 4 cycles, last on the 4th, done once, frame_cnt=1.
REQ-034 Parity build, in_data=4'b1011 -> par_valid=1 for 1 cycle after the last data bit, par_bit=1, done coincident with par_valid.
REQ-035 GAP=3, in_valid held high with words 0101 then 1100 -> second load occurs exactly 3 GAP + 1 IDLE cycles after the first frame ends; pin=1100.
REQ-036 Toggle in_data to 0000 during SHIFT of word 1011 -> pin stays 1011 and frame length stays 4.
REQ-037 Assert rst in the 2nd frame cycle -> next cycle all strobes=0, in_ready=1, frame_cnt unchanged at 0.
REQ-038 Send 256 back-to-back frames -> frame_cnt wraps to 0 after the 256th done pulse.
